// File: rtl/mux_scan_serializer_pkg.sv
// rtl/mux_scan_serializer_pkg.sv - shared types and constants for the mux scan serializer
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } scan_state_t;

    // The downstream multiplexor6 is fixed at 64:1, so the width is constant.
    localparam int WIDTH = 64;
    localparam int SEL_W = 6;

    localparam bit LSB_FIRST_DEFAULT = 1'b1;

    // First select of a word: bit 0 when streaming LSB first, bit 63 otherwise.
    function automatic logic [SEL_W-1:0] sel_first_of(input bit lsb_first);
        return lsb_first ? SEL_W'(0) : SEL_W'(WIDTH - 1);
    endfunction

    // Select of the final data beat of a word.
    function automatic logic [SEL_W-1:0] sel_end_of(input bit lsb_first);
        return lsb_first ? SEL_W'(WIDTH - 1) : SEL_W'(0);
    endfunction

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first_of(LSB_FIRST_DEFAULT);
    localparam logic [SEL_W-1:0] SEL_END   = sel_end_of(LSB_FIRST_DEFAULT);

endpackage

// File: rtl/mux_scan_serializer_if.sv
// rtl/mux_scan_serializer_if.sv - load port, serial port and status bundle
interface mux_scan_serializer_if;
    import mux_scan_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic [SEL_W-1:0] mux_sel;
    logic             busy;

    // Serializer side.
    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_data, ser_last, mux_sel, busy
    );

    // Word producer / bit consumer side.
    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_data, ser_last, mux_sel, busy
    );

endinterface

// File: rtl/mux_scan_serializer_mux6.sv
// rtl/mux_scan_serializer_mux6.sv - 64:1 single-bit multiplexor (multiplexor6)
module multiplexor6
    import mux_scan_pkg::*;
(
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0] sel,
    output logic             data_out
);

    // Pure combinational bit select.
    always_comb begin
        data_out = data_in[sel];
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - 64-bit word to serial stream via multiplexor6; optional MUX_SCAN_PARITY_EN
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_serializer_if.slave  bus
);

    localparam logic [SEL_W-1:0] SEL_START = sel_first_of(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_STOP  = sel_end_of(LSB_FIRST);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [WIDTH-1:0] hold_q;
    logic [SEL_W-1:0] sel_q;
    logic             mux_bit;
    logic             at_end;
    logic             load_fire;
    logic             beat_fire;

    assign at_end    = (sel_q == SEL_STOP);
    assign load_fire = (state_q == IDLE) && bus.load_valid;
    assign beat_fire = (state_q == SHIFT) && bus.ser_ready;

    multiplexor6 u_mux (
        .data_in  (hold_q),
        .sel      (sel_q),
        .data_out (mux_bit)
    );

    // State register; reset drops any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one word per load, leave SHIFT only after the end-index beat is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready && at_end) begin
`ifdef MUX_SCAN_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MUX_SCAN_PARITY_EN
            PARITY: begin
                if (bus.ser_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Word holding register and select counter; the counter stops at the end index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            sel_q  <= '0;
        end else if (load_fire) begin
            hold_q <= bus.load_data;
            sel_q  <= SEL_START;
        end else if (beat_fire && !at_end) begin
            sel_q  <= LSB_FIRST ? (sel_q + SEL_W'(1)) : (sel_q - SEL_W'(1));
        end
    end

    // Port outputs decoded from the current state.
    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.mux_sel    = sel_q;
`ifdef MUX_SCAN_PARITY_EN
        bus.ser_valid  = (state_q == SHIFT) || (state_q == PARITY);
        bus.ser_last   = (state_q == PARITY);
        bus.ser_data   = (state_q == PARITY) ? ^hold_q : mux_bit;
`else
        bus.ser_valid  = (state_q == SHIFT);
        bus.ser_last   = (state_q == SHIFT) && at_end;
        bus.ser_data   = mux_bit;
`endif
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - directed vector bench for mux_scan_serializer
module tb_mux_scan_serializer;
    import mux_scan_pkg::*;

`ifdef MUX_SCAN_PARITY_EN
    localparam int NBEATS = 65;
`else
    localparam int NBEATS = 64;
`endif

    typedef struct {
        logic [63:0] data;
        logic [63:0] exp_bits;
        logic        exp_par;
        int          stall_at;
        logic        stall_bit;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mux_scan_serializer_if bus ();

    mux_scan_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load_ready"}, 64'(bus.load_ready), 64'd1);
        chk({tag, "_ser_valid"},  64'(bus.ser_valid),  64'd0);
        chk({tag, "_ser_last"},   64'(bus.ser_last),   64'd0);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_mux_sel"},    64'(bus.mux_sel),    64'd0);
    endtask

    // Loads one word and streams it out, optionally stalling 3 cycles at one beat.
    task automatic run_word(input vec_t v, input string tag);
        logic [63:0] got;
        logic        par_got;
        int beat, cyc, stalled, sel_err, last_err, hold_err, valid_err, exp_sel, exp_cyc;
        @(negedge clk);
        chk({tag, "_pre_load_ready"}, 64'(bus.load_ready), 64'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        got = '0; par_got = 1'b0;
        beat = 0; cyc = 0; stalled = 0;
        sel_err = 0; last_err = 0; hold_err = 0; valid_err = 0;
        while (beat < NBEATS && cyc < 300) begin
            if (beat == v.stall_at && stalled < 3) begin
                bus.ser_ready = 1'b0;
                stalled++;
            end else begin
                bus.ser_ready = 1'b1;
            end
            if (!bus.ser_valid) begin
                valid_err++;
            end else begin
                exp_sel = (beat < 64) ? beat : 63;
                if (int'(bus.mux_sel) != exp_sel) sel_err++;
                if (bus.ser_last !== (beat == NBEATS - 1)) last_err++;
                if (beat == v.stall_at && bus.ser_data !== v.stall_bit) hold_err++;
                if (bus.ser_ready) begin
                    if (beat < 64) got[beat] = bus.ser_data;
                    else par_got = bus.ser_data;
                    beat++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        bus.ser_ready = 1'b1;
        exp_cyc = NBEATS + ((v.stall_at >= 0) ? 3 : 0);
        chk({tag, "_beats"},      64'(beat),      64'(NBEATS));
        chk({tag, "_bits"},       got,            v.exp_bits);
        chk({tag, "_sel_steps"},  64'(sel_err),   64'd0);
        chk({tag, "_last_beat"},  64'(last_err),  64'd0);
        chk({tag, "_stall_hold"}, 64'(hold_err),  64'd0);
        chk({tag, "_valid_gap"},  64'(valid_err), 64'd0);
        chk({tag, "_cycles"},     64'(cyc),       64'(exp_cyc));
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_parity"},     64'(par_got),   64'(v.exp_par));
`endif
        chk({tag, "_post_load_ready"}, 64'(bus.load_ready), 64'd1);
        chk({tag, "_post_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_post_ser_valid"},  64'(bus.ser_valid),  64'd0);
    endtask

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        logic [63:0] got;
        int beat, cyc;

        vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, -1, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, -1, 1'b0};
        vecs[2] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0,  5, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0007, 1'b1, -1, 1'b0};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 63, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,  0, 1'b0};

        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.ser_ready  = 1'b1;

        // Reset state, while reset is held and after release.
        @(negedge clk);
        chk_reset_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i], $sformatf("vec%0d", i));
        end

        // Load pulse at beat 10 is ignored; reset at beat 20 drops the word.
        w = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        got = '0; beat = 0; cyc = 0;
        while (beat < 20 && cyc < 100) begin
            if (beat == 10) begin
                bus.load_valid = 1'b1;
                bus.load_data  = ~w;
                chk("busy_load_ready", 64'(bus.load_ready), 64'd0);
            end else begin
                bus.load_valid = 1'b0;
            end
            if (bus.ser_valid) begin
                got[beat] = bus.ser_data;
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        chk("midword_bits", got & 64'hF_FFFF, w & 64'hF_FFFF);
        chk("midword_sel", 64'(bus.mux_sel), 64'd20);
        chk("midword_last", 64'(bus.ser_last), 64'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        chk("async_rst_ser_data", 64'(bus.ser_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_rst");

        run_word(vecs[2], "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
